// File: rtl/irrigation_sequencer.sv
// -----------------------------------------------------------------------------
// irrigation_sequencer
//   Central controller of the residential irrigation system. The tank level
//   sensors and the soil/rain sensors pass through 2-FF synchronisers. The
//   level vector is then debounced, and the resulting filtered levels drive
//   the irrigation FSM (sprinkler / drip / cooldown / error) and the fill valve
//   hysteresis. A one-cycle 'pulse' strobe tells the display decoder that the
//   state or the filtered levels changed.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   tick              1-cycle time-base enable, synchronous to clk
//   l, m, h           raw tank level sensors (1 = water present), asynchronous
//   soil_dry, rain    raw soil / rain sensors, asynchronous
//   l_f, m_f, h_f     filtered tank levels
//   As, Gt            sprinkler / drip valves (also decoder mode lines)
//   valve_in          tank fill valve
//   alarm             invalid filtered level combination
//   state             FSM code: IDLE=0 SPRINKLE=1 DRIP=2 COOLDOWN=3 ERROR=4
//   pulse             1-cycle display refresh strobe
// -----------------------------------------------------------------------------
module irrigation_sequencer #(
    parameter int FILT_CYCLES    = 4,
    parameter int SPRINKLE_TICKS = 60,
    parameter int DRIP_TICKS     = 120,
    parameter int COOL_TICKS     = 10,
    parameter int TIMER_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       l,
    input  logic       m,
    input  logic       h,
    input  logic       soil_dry,
    input  logic       rain,
    output logic       l_f,
    output logic       m_f,
    output logic       h_f,
    output logic       As,
    output logic       Gt,
    output logic       valve_in,
    output logic       alarm,
    output logic [2:0] state,
    output logic       pulse
);

    localparam int CNT_W = $clog2(FILT_CYCLES + 1);

    // The counter holds the number of identical samples seen after the first
    // sample of a run. So a value of FILT_CYCLES-1 means FILT_CYCLES identical
    // samples in a row.
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FILT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SPR_LAST = TIMER_W'(SPRINKLE_TICKS - 1);
    localparam logic [TIMER_W-1:0] DRP_LAST = TIMER_W'(DRIP_TICKS - 1);
    localparam logic [TIMER_W-1:0] CL_LAST  = TIMER_W'(COOL_TICKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SPRINKLE = 3'd1,
        ST_DRIP     = 3'd2,
        ST_COOL     = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    // Only the tank-filling staircase patterns are physically possible.
    function automatic logic lvl_valid(input logic [2:0] v);
        logic ok;
        case (v)
            3'b000, 3'b001, 3'b011, 3'b111: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Synchroniser bit order: {rain, soil_dry, h, m, l}
    logic [4:0]         sync1_q, sync1_d;
    logic [4:0]         sync2_q, sync2_d;
    logic [2:0]         prev_lvl_q, prev_lvl_d;
    logic [CNT_W-1:0]   filt_cnt_q, filt_cnt_d;
    logic [2:0]         filt_q, filt_d;          // {h_f, m_f, l_f}
    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               as_q, as_d;
    logic               gt_q, gt_d;
    logic               alarm_q, alarm_d;
    logic               valve_q, valve_d;
    logic               pulse_q, pulse_d;
    logic               init_q, init_d;

    logic [2:0] lvl_s;
    logic       dry_s;
    logic       rain_s;
    logic       want_water;

    always_comb begin
        sync1_d = {rain, soil_dry, h, m, l};
        sync2_d = sync1_q;

        lvl_s  = sync2_q[2:0];
        dry_s  = sync2_q[3];
        rain_s = sync2_q[4];

        // Level debounce: any change restarts the run of identical samples.
        prev_lvl_d = lvl_s;
        if (lvl_s != prev_lvl_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q != CNT_LAST) begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end else begin
            filt_cnt_d = filt_cnt_q;
        end
        // Once the run is long enough, reloading the same value is harmless.
        filt_d = (filt_cnt_d == CNT_LAST) ? lvl_s : filt_q;

        want_water = dry_s & ~rain_s;

        state_d = state_q;
        if (!lvl_valid(filt_q)) begin
            state_d = ST_ERROR;
        end else begin
            case (state_q)
                ST_ERROR: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (want_water && filt_q[2]) begin
                        state_d = ST_SPRINKLE;
                    end else if (want_water && filt_q[1]) begin
                        state_d = ST_DRIP;
                    end
                end
                ST_SPRINKLE: begin
                    if (!want_water || !filt_q[1]) begin
                        state_d = ST_COOL;
                    end else if (tick && timer_q == SPR_LAST) begin
                        state_d = ST_COOL;
                    end
                end
                ST_DRIP: begin
                    if (!want_water || !filt_q[0]) begin
                        state_d = ST_COOL;
                    end else if (tick && timer_q == DRP_LAST) begin
                        state_d = ST_COOL;
                    end
                end
                ST_COOL: begin
                    if (tick && timer_q == CL_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A state change (including an abort on a tick cycle) clears the timer,
        // so an aborting tick never advances it.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (tick && (state_q == ST_SPRINKLE || state_q == ST_DRIP ||
                              state_q == ST_COOL)) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        as_d    = (state_d == ST_SPRINKLE);
        gt_d    = (state_d == ST_DRIP);
        alarm_d = (state_d == ST_ERROR);

        // The fill valve looks at the same filtered vector as the FSM. An invalid
        // vector therefore cannot open it for a cycle before ERROR is entered.
        if (state_d == ST_ERROR) begin
            valve_d = 1'b0;
        end else if (!filt_q[1]) begin
            valve_d = 1'b1;
        end else if (filt_q[2]) begin
            valve_d = 1'b0;
        end else begin
            valve_d = valve_q;
        end

        init_d  = 1'b0;
        pulse_d = init_q | (state_d != state_q) | (filt_d != filt_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_lvl_q <= '0;
            filt_cnt_q <= '0;
            filt_q     <= '0;
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            as_q       <= 1'b0;
            gt_q       <= 1'b0;
            alarm_q    <= 1'b0;
            valve_q    <= 1'b0;
            pulse_q    <= 1'b0;
            init_q     <= 1'b1;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_lvl_q <= prev_lvl_d;
            filt_cnt_q <= filt_cnt_d;
            filt_q     <= filt_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            as_q       <= as_d;
            gt_q       <= gt_d;
            alarm_q    <= alarm_d;
            valve_q    <= valve_d;
            pulse_q    <= pulse_d;
            init_q     <= init_d;
        end
    end

    assign l_f      = filt_q[0];
    assign m_f      = filt_q[1];
    assign h_f      = filt_q[2];
    assign As       = as_q;
    assign Gt       = gt_q;
    assign valve_in = valve_q;
    assign alarm    = alarm_q;
    assign state    = state_q;
    assign pulse    = pulse_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// -----------------------------------------------------------------------------
// tb_irrigation_sequencer
//   Directed bench for irrigation_sequencer. Inputs change on the falling
//   edge, and outputs are sampled on the falling edge. Each scenario task
//   checks its own expected values and prints them inline.
// -----------------------------------------------------------------------------
module tb_irrigation_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       l, m, h;
    logic       soil_dry, rain;
    logic       l_f, m_f, h_f;
    logic       As, Gt, valve_in, alarm;
    logic [2:0] state;
    logic       pulse;

    int nvec  = 0;
    int nfail = 0;

    irrigation_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .l        (l),
        .m        (m),
        .h        (h),
        .soil_dry (soil_dry),
        .rain     (rain),
        .l_f      (l_f),
        .m_f      (m_f),
        .h_f      (h_f),
        .As       (As),
        .Gt       (Gt),
        .valve_in (valve_in),
        .alarm    (alarm),
        .state    (state),
        .pulse    (pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic set_lv(input logic [2:0] v);
        {h, m, l} = v;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One tick, held high across exactly one rising edge. The task returns
    // on the falling edge just after that rising edge.
    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b0;
        set_lv(3'b111); soil_dry = 1'b1; rain = 1'b0;
        wait_clk(3);
        nvec++; if (state !== 3'd0) begin nfail++; $display("FAIL rst_state: got %0d expected 0", state); end
        nvec++; if ({As, Gt, valve_in, alarm} !== 4'b0000) begin nfail++; $display("FAIL rst_outs: got %b expected 0000", {As, Gt, valve_in, alarm}); end
        nvec++; if ({h_f, m_f, l_f} !== 3'b000) begin nfail++; $display("FAIL rst_filt: got %b expected 000", {h_f, m_f, l_f}); end
        nvec++; if (pulse !== 1'b0) begin nfail++; $display("FAIL rst_pulse: got %b expected 0", pulse); end
    endtask

    task automatic test_sprinkle_run();
        int pcount;
        int bad;
        pcount = 0;
        @(negedge clk) reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (pulse === 1'b1) pcount++;
            if (i == 1) begin
                nvec++; if (pulse !== 1'b1) begin nfail++; $display("FAIL init_pulse: got %b expected 1", pulse); end
            end
            if (i == 5) begin
                nvec++; if ({h_f, m_f, l_f} !== 3'b000) begin nfail++; $display("FAIL filt_early: got %b expected 000", {h_f, m_f, l_f}); end
            end
            if (i == 6) begin
                nvec++; if ({h_f, m_f, l_f} !== 3'b111) begin nfail++; $display("FAIL filt_lat: got %b expected 111", {h_f, m_f, l_f}); end
            end
            if (i == 7) begin
                nvec++; if (state !== 3'd1 || As !== 1'b1 || Gt !== 1'b0) begin nfail++; $display("FAIL spr_enter: got state %0d As %b Gt %b expected 1 1 0", state, As, Gt); end
                nvec++; if (valve_in !== 1'b0) begin nfail++; $display("FAIL spr_fill: got %b expected 0", valve_in); end
            end
        end
        nvec++; if (pcount !== 3) begin nfail++; $display("FAIL spr_pulses: got %0d expected 3", pcount); end

        bad = 0;
        for (int t = 1; t <= 60; t++) begin
            do_tick();
            if (t < 60 && state !== 3'd1) bad++;
        end
        nvec++; if (bad !== 0) begin nfail++; $display("FAIL spr_early_exit: got %0d bad ticks expected 0", bad); end
        nvec++; if (state !== 3'd3 || As !== 1'b0 || pulse !== 1'b1) begin nfail++; $display("FAIL spr_to_cool: got state %0d As %b pulse %b expected 3 0 1", state, As, pulse); end

        bad = 0;
        for (int t = 1; t <= 9; t++) begin
            do_tick();
            if (state !== 3'd3) bad++;
        end
        nvec++; if (bad !== 0) begin nfail++; $display("FAIL cool_early_exit: got %0d bad ticks expected 0", bad); end
        rain = 1'b1;
        wait_clk(2);
        do_tick();
        nvec++; if (state !== 3'd0 || pulse !== 1'b1) begin nfail++; $display("FAIL cool_to_idle: got state %0d pulse %b expected 0 1", state, pulse); end
        wait_clk(2);
        nvec++; if (state !== 3'd0) begin nfail++; $display("FAIL rain_holds_idle: got %0d expected 0", state); end
    endtask

    task automatic test_drip_abort();
        int cnt;
        int bad;
        set_lv(3'b011);
        wait_clk(8);
        nvec++; if ({h_f, m_f, l_f} !== 3'b011 || state !== 3'd0) begin nfail++; $display("FAIL drip_pre: got filt %b state %0d expected 011 0", {h_f, m_f, l_f}, state); end
        rain = 1'b0;
        cnt = 0;
        while (state !== 3'd2 && cnt < 10) begin @(negedge clk); cnt++; end
        nvec++; if (cnt !== 3) begin nfail++; $display("FAIL drip_latency: got %0d cycles expected 3", cnt); end
        nvec++; if (Gt !== 1'b1 || As !== 1'b0) begin nfail++; $display("FAIL drip_valves: got Gt %b As %b expected 1 0", Gt, As); end
        bad = 0;
        for (int t = 1; t <= 4; t++) begin
            do_tick();
            if (state !== 3'd2 || Gt !== 1'b1) bad++;
        end
        nvec++; if (bad !== 0) begin nfail++; $display("FAIL drip_run: got %0d bad ticks expected 0", bad); end
        soil_dry = 1'b0;
        wait_clk(2);
        nvec++; if (state !== 3'd2) begin nfail++; $display("FAIL drip_sync_delay: got %0d expected 2", state); end
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        nvec++; if (state !== 3'd3 || Gt !== 1'b0 || pulse !== 1'b1) begin nfail++; $display("FAIL drip_abort: got state %0d Gt %b pulse %b expected 3 0 1", state, Gt, pulse); end
        bad = 0;
        for (int t = 1; t <= 9; t++) begin
            do_tick();
            if (state !== 3'd3) bad++;
        end
        nvec++; if (bad !== 0) begin nfail++; $display("FAIL abort_timer_clear: got %0d bad ticks expected 0", bad); end
        do_tick();
        nvec++; if (state !== 3'd0) begin nfail++; $display("FAIL drip_cool_done: got %0d expected 0", state); end
    endtask

    task automatic test_filter_glitch();
        int bad;
        set_lv(3'b001);
        wait_clk(8);
        nvec++; if ({h_f, m_f, l_f} !== 3'b001) begin nfail++; $display("FAIL glitch_pre: got %b expected 001", {h_f, m_f, l_f}); end
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            l = k[0];
            repeat (2) begin
                @(negedge clk);
                if ({h_f, m_f, l_f} !== 3'b001 || pulse !== 1'b0) bad++;
            end
        end
        l = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i <= 5 && ({h_f, m_f, l_f} !== 3'b001 || pulse !== 1'b0)) bad++;
            if (i == 6) begin
                nvec++; if ({h_f, m_f, l_f} !== 3'b000 || pulse !== 1'b1) begin nfail++; $display("FAIL glitch_accept: got filt %b pulse %b expected 000 1", {h_f, m_f, l_f}, pulse); end
            end
        end
        nvec++; if (bad !== 0) begin nfail++; $display("FAIL glitch_reject: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_error();
        int cnt;
        set_lv(3'b101);
        cnt = 0;
        while (state !== 3'd4 && cnt < 12) begin @(negedge clk); cnt++; end
        nvec++; if (cnt !== 7) begin nfail++; $display("FAIL err_latency: got %0d cycles expected 7", cnt); end
        nvec++; if (alarm !== 1'b1 || {As, Gt, valve_in} !== 3'b000) begin nfail++; $display("FAIL err_outs: got alarm %b valves %b expected 1 000", alarm, {As, Gt, valve_in}); end
        wait_clk(3);
        nvec++; if (valve_in !== 1'b0 || state !== 3'd4) begin nfail++; $display("FAIL err_hold: got valve %b state %0d expected 0 4", valve_in, state); end
        set_lv(3'b111);
        cnt = 0;
        while (state !== 3'd0 && cnt < 12) begin @(negedge clk); cnt++; end
        nvec++; if (cnt !== 7 || alarm !== 1'b0) begin nfail++; $display("FAIL err_recover: got %0d cycles alarm %b expected 7 0", cnt, alarm); end
        nvec++; if (valve_in !== 1'b0) begin nfail++; $display("FAIL err_fill_after: got %b expected 0", valve_in); end
    endtask

    task automatic test_fill_hyst();
        logic [2:0] lv  [4];
        logic       exp [4];
        lv[0] = 3'b001; exp[0] = 1'b1;
        lv[1] = 3'b011; exp[1] = 1'b1;
        lv[2] = 3'b111; exp[2] = 1'b0;
        lv[3] = 3'b011; exp[3] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            set_lv(lv[s]);
            wait_clk(9);
            nvec++; if (valve_in !== exp[s] || {h_f, m_f, l_f} !== lv[s]) begin nfail++; $display("FAIL fill_step%0d: got valve %b filt %b expected %b %b", s, valve_in, {h_f, m_f, l_f}, exp[s], lv[s]); end
        end
    endtask

    task automatic test_reset_midrun();
        int cnt;
        int bad;
        set_lv(3'b111);
        wait_clk(8);
        soil_dry = 1'b1;
        cnt = 0;
        while (state !== 3'd1 && cnt < 10) begin @(negedge clk); cnt++; end
        for (int t = 1; t <= 30; t++) do_tick();
        nvec++; if (As !== 1'b1 || state !== 3'd1) begin nfail++; $display("FAIL mid_pre: got As %b state %0d expected 1 1", As, state); end
        #2 reset = 1'b1;
        #1;
        nvec++; if (As !== 1'b0 || state !== 3'd0 || valve_in !== 1'b0 || pulse !== 1'b0) begin nfail++; $display("FAIL mid_async: got As %b state %0d valve %b pulse %b expected 0 0 0 0", As, state, valve_in, pulse); end
        wait_clk(2);
        reset = 1'b0;
        @(negedge clk);
        nvec++; if (pulse !== 1'b1 || state !== 3'd0) begin nfail++; $display("FAIL mid_init: got pulse %b state %0d expected 1 0", pulse, state); end
        cnt = 1;
        while (state !== 3'd1 && cnt < 12) begin @(negedge clk); cnt++; end
        nvec++; if (cnt !== 7) begin nfail++; $display("FAIL mid_reenter: got %0d cycles expected 7", cnt); end
        bad = 0;
        for (int t = 1; t <= 60; t++) begin
            do_tick();
            if (t < 60 && state !== 3'd1) bad++;
        end
        nvec++; if (bad !== 0 || state !== 3'd3) begin nfail++; $display("FAIL mid_timer_restart: got %0d bad ticks state %0d expected 0 3", bad, state); end
    endtask

    initial begin
        test_reset();
        test_sprinkle_run();
        test_drip_abort();
        test_filter_glitch();
        test_error();
        test_fill_hyst();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
